sfp_seq: RTL and testbench
==========================

// Module: sfp_seq
// PURPOSE
//  Command sequencer (initiator) that drives one sfp accumulate/ReLU lane.
//  Accepts a job (start, num_acc, relu_en, thres), streams num_acc operands
//  from a valid/ready input into the lane via sfp_acc, issues one sfp_relu,
//  captures the lane result and offers it on a valid/ready output.
//  Sits between the PE-array psum stream and the output SRAM writer.
// PARAMETERS
//  bw       8   operand width (sfp_in / in_data)
//  psum_bw  16  psum width (sfp_out / out_data / thres)
//  cnt_bw   8   width of num_acc and the internal operand counter
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high
//  start      in   1        job request; sampled only in IDLE
//  num_acc    in   cnt_bw   operands per job (0 allowed)
//  relu_en    in   1        1: issue sfp_relu after the last operand
//  thres      in   psum_bw  ReLU threshold (signed)
//  in_valid   in   1        operand valid
//  in_ready   out  1        operand ready
//  in_data    in   bw       operand (signed)
//  sfp_in     out  bw       to sfp.in
//  sfp_acc    out  1        to sfp.acc
//  sfp_relu   out  1        to sfp.relu
//  sfp_thres  out  psum_bw  to sfp.thres
//  sfp_clr    out  1        ORed with reset at sfp.reset (psum clear)
//  sfp_out    in   psum_bw  from sfp.out
//  out_valid  out  1        result valid
//  out_ready  in   1        result ready
//  out_data   out  psum_bw  result (signed)
//  busy       out  1        state != IDLE
//  done       out  1        1-cycle pulse, cycle after the result handshake
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready, sfp_acc, sfp_relu, sfp_clr, out_valid,
//    busy, done = 0; sfp_in, sfp_thres, out_data, counter = 0. Reset
//    mid-job abandons the job with no output; the next job starts clean.
//  - FSM: IDLE -> CLR -> ACC -> RELU -> CAPT -> OUT -> IDLE.
//  - IDLE: start=1 latches num_acc, relu_en, thres; next state CLR.
//    start outside IDLE is ignored.
//  - CLR (1 cycle): sfp_clr=1. Next: ACC if num_acc!=0, else RELU.
//  - ACC: in_ready=1. sfp_acc = in_valid & in_ready; sfp_in = in_data
//    (combinational, same cycle). Counter increments per handshake. Handshake
//    with counter==num_acc-1 -> RELU. Gaps in in_valid are no-ops: no acc pulse.
//  - RELU (1 cycle): sfp_relu = latched relu_en, sfp_acc=0. sfp_thres holds
//    the latched thres for the whole job.
//  - CAPT (1 cycle): out_data <= sfp_out (psum after ReLU edge).
//  - OUT: out_valid=1; out_data stable until out_valid & out_ready, then
//    IDLE with done=1 in the following cycle.
//  - sfp_acc and sfp_relu are never high together; sfp_acc=0 outside ACC.
//  - Latency, zero-bubble input, out_ready=1: start in cycle 0 -> CLR c1 ->
//    acc c2..c(N+1) -> RELU c(N+2) -> CAPT c(N+3) -> out_valid c(N+4),
//    done c(N+5). num_acc=0: out_valid in c4, result 0.
//  - Arithmetic is owned by sfp (psum_bw wrap, signed compare); out_data
//    equals sfp_out bit-for-bit. Counter never wraps: num_acc <= 2^cnt_bw-1.
// TESTING (bench: sfp_seq + sfp, reset = reset | sfp_clr)
//  1 Reset 3 cycles -> all outputs 0, busy=0; start held in reset -> no job.
//  2 num_acc=4, relu_en=0, in 10,20,-5,3 back-to-back -> out_data=28,
//    out_valid in c8, done in c9, exactly 4 sfp_acc pulses.
//  3 relu_en=1, thres=30, in 10,18 -> out 0; thres=30, in 25,15 -> out 40;
//    thres=0, in -10,-20 -> out 0.
//  4 in_valid gaps of 3 cycles and out_ready low 5 cycles -> no extra acc
//    pulses, out_data stable, start pulses while busy ignored.
//  5 num_acc=0, relu_en=1, thres=5 -> out_data=0, out_valid in c4.
//  6 reset during ACC after 2 of 4 operands -> IDLE next cycle, no out_valid;
//    new job in 7,8 -> out 15 (no stale psum).

Source files
------------

// File: rtl/sfp_seq.sv
// Command sequencer driving one sfp accumulate/ReLU lane: clear, stream
// operands, optional ReLU, capture the psum and offer it downstream.
module sfp_seq #(
  parameter int unsigned bw      = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_bw-1:0]  num_acc,
  input  logic               relu_en,
  input  logic [psum_bw-1:0] thres,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_data,
  output logic [bw-1:0]      sfp_in,
  output logic               sfp_acc,
  output logic               sfp_relu,
  output logic [psum_bw-1:0] sfp_thres,
  output logic               sfp_clr,
  input  logic [psum_bw-1:0] sfp_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ACC  = 3'd2,
    RELU = 3'd3,
    CAPT = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [cnt_bw-1:0]   num_acc_q;
  logic                relu_en_q;
  logic [psum_bw-1:0]  thres_q;
  logic [cnt_bw-1:0]   cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and lane command decode; operand path is same-cycle
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    sfp_in    = '0;
    sfp_acc   = 1'b0;
    sfp_relu  = 1'b0;
    sfp_clr   = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = CLR;
      end
      CLR: begin
        sfp_clr = 1'b1;
        state_n = (num_acc_q != '0) ? ACC : RELU;
      end
      ACC: begin
        in_ready = 1'b1;
        sfp_in   = in_data;
        sfp_acc  = in_valid;
        if (in_valid && (cnt == num_acc_q - cnt_bw'(1))) state_n = RELU;
      end
      RELU: begin
        sfp_relu = relu_en_q;
        state_n  = CAPT;
      end
      CAPT: begin
        state_n = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign sfp_thres = thres_q;

  // Job parameters, operand counter, result capture and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      num_acc_q <= '0;
      relu_en_q <= 1'b0;
      thres_q   <= '0;
      cnt       <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == OUT) && out_ready;
      if ((state == IDLE) && start) begin
        num_acc_q <= num_acc;
        relu_en_q <= relu_en;
        thres_q   <= thres;
      end
      if (state == CLR) cnt <= '0;
      else if ((state == ACC) && in_valid) cnt <= cnt + cnt_bw'(1);
      if (state == CAPT) out_data <= sfp_out;
    end
  end

endmodule

// File: tb/tb_sfp_seq.sv
// Bench for sfp_seq driving a behavioural sfp lane (reset | sfp_clr clears it).
module tb_sfp_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_acc;
  logic        relu_en;
  logic [15:0] thres;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  sfp_in;
  logic        sfp_acc;
  logic        sfp_relu;
  logic [15:0] sfp_thres;
  logic        sfp_clr;
  logic [15:0] sfp_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sfp_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_acc(num_acc),
    .relu_en(relu_en), .thres(thres), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .sfp_in(sfp_in),
    .sfp_acc(sfp_acc), .sfp_relu(sfp_relu), .sfp_thres(sfp_thres),
    .sfp_clr(sfp_clr), .sfp_out(sfp_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  // Behavioural sfp lane: signed accumulate, ReLU keeps psum only if > thres
  logic [15:0] psum;
  assign sfp_out = psum;
  always @(posedge clk) begin
    if (reset || sfp_clr)
      psum <= 16'd0;
    else if (sfp_acc)
      psum <= psum + {{8{sfp_in[7]}}, sfp_in};
    else if (sfp_relu)
      psum <= ($signed(psum) > $signed(sfp_thres)) ? psum : 16'd0;
  end

  typedef struct {
    logic [7:0]       n;
    logic             relu;
    logic [15:0]      thres;
    logic [3:0][7:0]  ops;
    logic [15:0]      exp;
  } job_t;

  function automatic job_t mk(input logic [7:0] n, input logic relu,
                              input logic [15:0] th, input logic [7:0] o0,
                              input logic [7:0] o1, input logic [7:0] o2,
                              input logic [7:0] o3, input logic [15:0] exp);
    job_t j;
    j.n = n; j.relu = relu; j.thres = th;
    j.ops[0] = o0; j.ops[1] = o1; j.ops[2] = o2; j.ops[3] = o3;
    j.exp = exp;
    return j;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One job: gap = idle cycles between operands, stall = cycles out_ready low
  task automatic run_job(input job_t j, input int gap, input int stall,
                         input bit spam_start, input string tag);
    int cyc, idx, gapcnt, pulses, ov_cyc, done_cyc, stall_cnt;
    logic [15:0] held;
    bit held_ok, both_hi, fin;
    cyc = 0; idx = 0; gapcnt = 0; pulses = 0; ov_cyc = -1; done_cyc = -1;
    stall_cnt = 0; held = '0; held_ok = 1; both_hi = 0; fin = 0;
    @(posedge clk); #1;
    start = 1'b1; num_acc = j.n; relu_en = j.relu; thres = j.thres;
    in_valid = 1'b0; in_data = 8'd0; out_ready = (stall == 0);
    while (cyc < 200) begin
      @(negedge clk);
      if (sfp_acc) pulses++;
      if (sfp_acc && sfp_relu) both_hi = 1;
      if (in_valid && in_ready) begin
        idx++;
        gapcnt = gap;
      end
      if (out_valid) begin
        if (ov_cyc < 0) begin
          ov_cyc = cyc;
          held = out_data;
        end else if (out_data !== held) held_ok = 0;
        if (!out_ready) stall_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        fin = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      start = spam_start && (idx < int'(j.n)) && cyc[0];
      num_acc = 8'hFF; relu_en = ~j.relu; thres = ~j.thres;
      if (gapcnt > 0) begin
        in_valid = 1'b0;
        gapcnt--;
      end else begin
        in_valid = (idx < int'(j.n));
      end
      in_data = (idx < int'(j.n)) ? j.ops[2'(idx)] : 8'hA5;
      out_ready = (stall_cnt >= stall);
    end
    check({tag, " timeout"}, 32'(fin), 32'd1);
    check({tag, " out_data"}, 32'(held), 32'(j.exp));
    check({tag, " acc_pulses"}, 32'(pulses), 32'(j.n));
    check({tag, " acc_relu_overlap"}, 32'(both_hi), 32'd0);
    check({tag, " out_data_stable"}, 32'(held_ok), 32'd1);
    if (gap == 0) check({tag, " out_valid_cycle"}, 32'(ov_cyc), 32'(int'(j.n) + 4));
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(ov_cyc + stall + 1));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " out_valid_at_done"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  job_t jobs [8];

  initial begin
    reset = 1'b1; start = 1'b1; num_acc = 8'd3; relu_en = 1'b0;
    thres = 16'd0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;

    jobs[0] = mk(8'd4, 1'b0, 16'd0,   8'd10, 8'd20, -8'sd5, 8'd3, 16'd28);
    jobs[1] = mk(8'd2, 1'b1, 16'd30,  8'd10, 8'd18, 8'd0, 8'd0, 16'd0);
    jobs[2] = mk(8'd2, 1'b1, 16'd30,  8'd25, 8'd15, 8'd0, 8'd0, 16'd40);
    jobs[3] = mk(8'd2, 1'b1, 16'd0,   -8'sd10, -8'sd20, 8'd0, 8'd0, 16'd0);
    jobs[4] = mk(8'd0, 1'b1, 16'd5,   8'd0, 8'd0, 8'd0, 8'd0, 16'd0);
    jobs[5] = mk(8'd1, 1'b0, 16'd0,   8'h80, 8'd0, 8'd0, 8'd0, 16'hFF80);
    jobs[6] = mk(8'd3, 1'b0, 16'd0,   8'd127, 8'd127, 8'd127, 8'd0, 16'd381);
    jobs[7] = mk(8'd2, 1'b1, 16'hFFCE, -8'sd10, -8'sd20, 8'd0, 8'd0, 16'hFFE2);

    // Reset held 3 cycles with start asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ctrl", 32'({in_ready, sfp_acc, sfp_relu, sfp_clr, out_valid, done}), 32'd0);
    end
    check("rst_data", 32'({sfp_in, sfp_thres}), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Table-driven back-to-back jobs
    for (int k = 0; k < 8; k++) run_job(jobs[k], 0, 0, 1'b0, $sformatf("job%0d", k));

    // Input gaps, output backpressure, start pulses while busy
    run_job(mk(8'd4, 1'b0, 16'd0, 8'd1, 8'd2, 8'd3, 8'd4, 16'd10), 3, 5, 1'b1, "gaps");

    // Reset during ACC after 2 of 4 operands
    @(posedge clk); #1;
    start = 1'b1; num_acc = 8'd4; relu_en = 1'b0; thres = 16'd0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'd100;
    @(posedge clk); #1;
    in_data = 8'd50;
    @(posedge clk); #1;
    in_data = 8'd1;
    @(negedge clk);
    check("midrst_in_acc", 32'(in_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    begin
      bit seen_ov;
      seen_ov = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (out_valid || busy) seen_ov = 1;
      end
      check("midrst_no_output", 32'(seen_ov), 32'd0);
    end
    run_job(mk(8'd2, 1'b0, 16'd0, 8'd7, 8'd8, 8'd0, 8'd0, 16'd15), 0, 0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
